sfx_voice_sequencer: RTL and testbench

SFX_VOICE_SEQUENCER -- requirements
Module: sfx_voice_sequencer

---
 rtl/sfx_voice_sequencer.sv | 131 +++++++++++++
 tb/tb_sfx_voice_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sfx_voice_sequencer.sv
// Sound-effect voice sequencer: picks one of NCH triggered channels and plays a
// fixed-length note as a sawtooth or square wave, with a global mute mode.
module sfx_voice_sequencer #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned DAC_W = 8,
    parameter int unsigned PER_W = 12,
    parameter int unsigned DUR_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         trig,
    input  logic                   mute_toggle,
    input  logic                   wave_sel,
    input  logic [NCH*PER_W-1:0]   period_i,
    input  logic [NCH*DUR_W-1:0]   dur_i,
    output logic [DAC_W-1:0]       dac_o,
    output logic                   active_o,
    output logic [$clog2(NCH)-1:0] chan_o,
    output logic                   muted_o
);
    localparam int unsigned CH_W = $clog2(NCH);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t            state_q, state_d;
    logic              muted_q, muted_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic [PER_W-1:0]  step_q, step_d;
    logic [DAC_W-1:0]  phase_q, phase_d;
    logic [DAC_W-1:0]  dac_q, dac_d;

    logic              found_c;
    logic [CH_W-1:0]   sel_c;
    logic [PER_W-1:0]  per_sel_c;
    logic [DUR_W-1:0]  dur_sel_c;
    logic              start_c;
    logic              mute_enter_c;

    // Lowest-index trigger with usable period and duration; mute blocks all starts
    always_comb begin
        found_c   = 1'b0;
        sel_c     = '0;
        per_sel_c = '0;
        dur_sel_c = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found_c && trig[i] &&
                (period_i[i*PER_W +: PER_W] != '0) &&
                (dur_i[i*DUR_W +: DUR_W] != '0)) begin
                found_c   = 1'b1;
                sel_c     = CH_W'(i);
                per_sel_c = period_i[i*PER_W +: PER_W];
                dur_sel_c = dur_i[i*DUR_W +: DUR_W];
            end
        end
        mute_enter_c = mute_toggle && !muted_q;
        start_c      = found_c && !muted_q && !mute_toggle &&
                       ((state_q == IDLE) || (sel_c <= chan_q));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mute_enter_c)                        state_d = IDLE;
        else if (start_c)                        state_d = PLAY;
        else if (state_q == PLAY && rem_q == '0) state_d = IDLE;
    end

    // rem counts remaining cycles after the current one; step/phase form the oscillator
    always_comb begin
        muted_d = muted_q ^ mute_toggle;
        chan_d  = chan_q;
        per_d   = per_q;
        rem_d   = rem_q;
        step_d  = step_q;
        phase_d = phase_q;
        if (start_c) begin
            chan_d  = sel_c;
            per_d   = per_sel_c;
            rem_d   = dur_sel_c - DUR_W'(1);
            step_d  = '0;
            phase_d = '0;
        end else if (state_q == PLAY) begin
            rem_d = rem_q - DUR_W'(1);
            if (step_q == per_q - PER_W'(1)) begin
                step_d  = '0;
                phase_d = phase_q + DAC_W'(1);
            end else begin
                step_d = step_q + PER_W'(1);
            end
        end
        if (state_d == IDLE) begin
            rem_d   = '0;
            step_d  = '0;
            phase_d = '0;
        end
        if (state_d == PLAY) dac_d = wave_sel ? {DAC_W{phase_d[DAC_W-1]}} : phase_d;
        else                 dac_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            muted_q <= 1'b0;
            chan_q  <= '0;
            per_q   <= '0;
            rem_q   <= '0;
            step_q  <= '0;
            phase_q <= '0;
            dac_q   <= '0;
        end else begin
            muted_q <= muted_d;
            chan_q  <= chan_d;
            per_q   <= per_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            dac_q   <= dac_d;
        end
    end

    assign dac_o    = dac_q;
    assign active_o = (state_q == PLAY);
    assign chan_o   = chan_q;
    assign muted_o  = muted_q;

endmodule

// File: tb/tb_sfx_voice_sequencer.sv
// Scoreboard bench for sfx_voice_sequencer: each driven cycle queues the
// outputs expected after the next edge, which are popped and compared at edge+1.
module tb_sfx_voice_sequencer;

    typedef struct packed {
        logic       act;
        logic [7:0] dac;
        logic [1:0] chan;
        logic       mut;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  trig;
    logic        mute_toggle;
    logic        wave_sel;
    logic [47:0] period_v;
    logic [39:0] dur_v;
    logic [7:0]  dac_o;
    logic        active_o;
    logic [1:0]  chan_o;
    logic        muted_o;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    sfx_voice_sequencer #(
        .NCH(4), .DAC_W(8), .PER_W(12), .DUR_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trig(trig),
        .mute_toggle(mute_toggle),
        .wave_sel(wave_sel),
        .period_i(period_v),
        .dur_i(dur_v),
        .dac_o(dac_o),
        .active_o(active_o),
        .chan_o(chan_o),
        .muted_o(muted_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        else             n_pass++;
    endtask

    function automatic exp_t mk(input logic a, input int d, input int c, input logic m);
        exp_t e;
        e.act  = a;
        e.dac  = 8'(d);
        e.chan = 2'(c);
        e.mut  = m;
        return e;
    endfunction

    task automatic set_ch(input int i, input int per, input int dur);
        period_v[i*12 +: 12] = 12'(per);
        dur_v[i*10 +: 10]    = 10'(dur);
    endtask

    // Drive one cycle of inputs, then compare the registered outputs after the edge
    task automatic cyc(input logic r, input logic [3:0] t, input logic mt, input exp_t e);
        exp_t x;
        @(negedge clk);
        rst         = r;
        trig        = t;
        mute_toggle = mt;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        x = sb_q.pop_front();
        check_eq("active", 32'(active_o), 32'(x.act));
        check_eq("dac",    32'(dac_o),    32'(x.dac));
        check_eq("chan",   32'(chan_o),   32'(x.chan));
        check_eq("muted",  32'(muted_o),  32'(x.mut));
    endtask

    task automatic idle(input int n, input int c, input logic m);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 0, c, m));
    endtask

    initial begin
        rst = 1'b1; trig = '0; mute_toggle = 1'b0; wave_sel = 1'b0;
        period_v = '0; dur_v = '0;
        for (int c = 0; c < 4; c++) set_ch(c, 1, 5);

        // Reset overrides simultaneous triggers
        cyc(1'b1, 4'b1111, 1'b0, mk(1'b0, 0, 0, 1'b0));
        cyc(1'b1, 4'b1111, 1'b0, mk(1'b0, 0, 0, 1'b0));
        idle(3, 0, 1'b0);

        // Sawtooth note, period 3 dur 10; mid-note slice change must be ignored
        set_ch(2, 3, 10);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) set_ch(2, 1, 1);
            cyc(1'b0, (k == 0) ? 4'b0100 : 4'b0000, 1'b0, mk(1'b1, k / 3, 2, 1'b0));
        end
        idle(2, 2, 1'b0);

        // Lowest index wins, higher index ignored, lower index preempts
        set_ch(0, 4, 8); set_ch(1, 2, 20); set_ch(2, 3, 10); set_ch(3, 1, 5);
        for (int k = 0; k < 6; k++)
            cyc(1'b0, (k == 0) ? 4'b0110 : ((k == 3) ? 4'b1000 : 4'b0000), 1'b0,
                mk(1'b1, k / 2, 1, 1'b0));
        for (int j = 0; j < 8; j++)
            cyc(1'b0, (j == 0) ? 4'b0001 : 4'b0000, 1'b0, mk(1'b1, j / 4, 0, 1'b0));
        idle(2, 0, 1'b0);

        // Full-speed ramp with wrap, then square wave on the same phase
        set_ch(0, 1, 300);
        for (int w = 0; w < 2; w++) begin
            wave_sel = w[0];
            for (int k = 0; k < 300; k++) begin
                int p;
                int d;
                p = k % 256;
                d = (w == 1) ? ((p >= 128) ? 255 : 0) : p;
                cyc(1'b0, (k == 0) ? 4'b0001 : 4'b0000, 1'b0, mk(1'b1, d, 0, 1'b0));
            end
            idle(2, 0, 1'b0);
        end
        wave_sel = 1'b0;

        // Mute aborts, blocks triggers, unmute beats a coincident trigger
        set_ch(1, 2, 20);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, (k == 0) ? 4'b0010 : 4'b0000, 1'b0, mk(1'b1, k / 2, 1, 1'b0));
        cyc(1'b0, 4'b0000, 1'b1, mk(1'b0, 0, 1, 1'b1));
        cyc(1'b0, 4'b0010, 1'b0, mk(1'b0, 0, 1, 1'b1));
        cyc(1'b0, 4'b0001, 1'b0, mk(1'b0, 0, 1, 1'b1));
        cyc(1'b0, 4'b0010, 1'b1, mk(1'b0, 0, 1, 1'b0));
        for (int k = 0; k < 20; k++)
            cyc(1'b0, (k == 0) ? 4'b0010 : 4'b0000, 1'b0, mk(1'b1, k / 2, 1, 1'b0));
        idle(2, 1, 1'b0);

        // Zero period or zero duration makes a trigger invalid
        set_ch(0, 0, 5); set_ch(1, 2, 3);
        for (int k = 0; k < 3; k++)
            cyc(1'b0, (k == 0) ? 4'b0011 : 4'b0000, 1'b0, mk(1'b1, k / 2, 1, 1'b0));
        idle(1, 1, 1'b0);
        set_ch(0, 2, 0);
        cyc(1'b0, 4'b0001, 1'b0, mk(1'b0, 0, 1, 1'b0));
        idle(1, 1, 1'b0);

        // Same-channel retrigger, then reset mid-note
        set_ch(2, 3, 10);
        for (int k = 0; k < 4; k++)
            cyc(1'b0, (k == 0) ? 4'b0100 : 4'b0000, 1'b0, mk(1'b1, k / 3, 2, 1'b0));
        cyc(1'b0, 4'b0100, 1'b0, mk(1'b1, 0, 2, 1'b0));
        cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 0, 2, 1'b0));
        cyc(1'b1, 4'b0000, 1'b0, mk(1'b0, 0, 0, 1'b0));
        idle(2, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
